// File: rtl/ldq_port_arbiter_if.sv
// Handshake bundle between the page-buffer requesters, the arbiter and the
// LDQ load port. Every channel uses the same rule: a transfer happens on a
// rising clk edge where valid and ready are both high; a producer holds valid
// and its payload stable until that edge, and ready may depend on valid.
interface ldq_port_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 512
);
   logic [NUM_REQ-1:0]        req_addr_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_addr_ready;
   logic                      ldq_addr_valid;
   logic [ADDR_W-1:0]         ldq_addr;
   logic                      ldq_addr_ready;
   logic                      ldq_data_valid;
   logic [DATA_W-1:0]         ldq_data;
   logic                      ldq_data_ready;
   logic [NUM_REQ-1:0]        req_data_valid;
   logic [DATA_W-1:0]         req_data;
   logic [NUM_REQ-1:0]        req_data_ready;

   // Arbiter side
   modport slave (
      input  req_addr_valid, req_addr, ldq_addr_ready, ldq_data_valid, ldq_data, req_data_ready,
      output req_addr_ready, ldq_addr_valid, ldq_addr, ldq_data_ready, req_data_valid, req_data
   );

   // Environment side (requesters plus LDQ)
   modport master (
      output req_addr_valid, req_addr, ldq_addr_ready, ldq_data_valid, ldq_data, req_data_ready,
      input  req_addr_ready, ldq_addr_valid, ldq_addr, ldq_data_ready, req_data_valid, req_data
   );
endinterface

// File: rtl/ldq_port_arbiter.sv
// Round-robin arbiter sharing one LDQ load port between NUM_REQ page buffers.
// Granted requester indices are queued in order so that each returning burst
// of BEATS_PER_REQ data beats is steered back to the requester that asked.
module ldq_port_arbiter #(
   parameter int   NUM_REQ       = 4,
   parameter int   BITS_REQ      = 2,
   parameter int   ADDR_W        = 16,
   parameter int   DATA_W        = 512,
   parameter int   BEATS_PER_REQ = 32,
   parameter int   BITS_BEATS    = 5,
   parameter int   ORDQ_ASIZE    = 4,
   parameter int   MAX_OUT       = 2,
   parameter logic MODE_WORK     = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 unit_en,
   input  logic                 mode,
   ldq_port_arbiter_if.slave    bus,
   output logic                 busy
);
   localparam int CW         = $clog2(MAX_OUT + 1);
   localparam int ORDQ_DEPTH = 1 << ORDQ_ASIZE;

   logic                         global_en;
   logic [NUM_REQ-1:0][CW-1:0]   credit;
   logic [NUM_REQ-1:0]           eligible;
   logic [BITS_REQ-1:0]          rr_ptr;
   logic [BITS_REQ-1:0]          grant_idx;
   logic [BITS_REQ-1:0]          scan_idx;
   logic                         grant_found;
   logic                         capture;
   logic                         addr_valid_q;
   logic [ADDR_W-1:0]            addr_q;
   logic [BITS_REQ-1:0]          ordq_mem [ORDQ_DEPTH];
   logic [ORDQ_ASIZE:0]          wr_ptr;
   logic [ORDQ_ASIZE:0]          rd_ptr;
   logic [ORDQ_ASIZE:0]          ordq_used;
   logic                         ordq_full;
   logic                         ordq_empty;
   logic [BITS_REQ-1:0]          owner;
   logic [BITS_BEATS-1:0]        beat_ctr;
   logic                         beat_fire;
   logic                         burst_done;

   assign global_en  = (mode == MODE_WORK) && unit_en;
   assign ordq_used  = wr_ptr - rd_ptr;
   assign ordq_full  = ordq_used[ORDQ_ASIZE];
   assign ordq_empty = (ordq_used == '0);
   assign owner      = ordq_mem[rd_ptr[ORDQ_ASIZE-1:0]];

   // A requester may be granted while it has fewer than MAX_OUT loads in flight
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.req_addr_valid[i] && (credit[i] < CW'(MAX_OUT));
      end
   end

   // Round-robin pick: first eligible index starting at rr_ptr
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = BITS_REQ'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && eligible[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Fullness is judged on the current occupancy, so a same-cycle pop never frees room
   assign capture = global_en && !ordq_full && grant_found && (!addr_valid_q || bus.ldq_addr_ready);

   assign bus.req_addr_ready = capture ? (NUM_REQ'(1) << grant_idx) : '0;
   assign bus.ldq_addr_valid = addr_valid_q;
   assign bus.ldq_addr       = addr_q;

   assign bus.req_data       = bus.ldq_data;
   assign bus.req_data_valid = (global_en && !ordq_empty && bus.ldq_data_valid) ? (NUM_REQ'(1) << owner) : '0;
   assign bus.ldq_data_ready = global_en && !ordq_empty && bus.req_data_ready[owner];

   assign beat_fire  = bus.ldq_data_valid && bus.ldq_data_ready;
   assign burst_done = beat_fire && (beat_ctr == BITS_BEATS'(BEATS_PER_REQ - 1));
   assign busy       = addr_valid_q || !ordq_empty;

   // Address output register: holds its address until the LDQ takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_valid_q <= 1'b0;
         addr_q       <= '0;
         rr_ptr       <= '0;
      end else if (capture) begin
         addr_valid_q <= 1'b1;
         addr_q       <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
         rr_ptr       <= BITS_REQ'((int'(grant_idx) + 1) % NUM_REQ);
      end else if (bus.ldq_addr_ready) begin
         addr_valid_q <= 1'b0;
      end
   end

   // Per-requester outstanding-load credits; simultaneous grant and completion cancel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((capture && grant_idx == BITS_REQ'(i)) && !(burst_done && owner == BITS_REQ'(i))) begin
               credit[i] <= credit[i] + CW'(1);
            end else if ((burst_done && owner == BITS_REQ'(i)) && !(capture && grant_idx == BITS_REQ'(i))) begin
               credit[i] <= credit[i] - CW'(1);
            end
         end
      end
   end

   // Grant-order queue pointers and the beat counter within the head burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         beat_ctr <= '0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (burst_done) begin
            rd_ptr   <= rd_ptr + 1'b1;
            beat_ctr <= '0;
         end else if (beat_fire) begin
            beat_ctr <= beat_ctr + 1'b1;
         end
      end
   end

   // Grant-order queue storage; contents are meaningless while the pointers say empty
   always_ff @(posedge clk) begin
      if (capture) begin
         ordq_mem[wr_ptr[ORDQ_ASIZE-1:0]] <= grant_idx;
      end
   end
endmodule

// File: tb/tb_ldq_port_arbiter.sv
// Bench for ldq_port_arbiter: a vector table for round-robin granting, then
// hand-written sequences for address stalls, burst steering with requester
// back-pressure, and a burst completing in the same cycle as a new grant.
module tb_ldq_port_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 512;
   localparam int BEATS   = 32;

   logic clk = 1'b0;
   logic rst;
   logic unit_en;
   logic mode;
   logic busy;

   ldq_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ldq_port_arbiter #(
      .NUM_REQ(NUM_REQ), .BITS_REQ(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .BEATS_PER_REQ(BEATS), .BITS_BEATS(5), .ORDQ_ASIZE(4), .MAX_OUT(2)
   ) dut (
      .clk(clk), .rst(rst), .unit_en(unit_en), .mode(mode), .bus(bus), .busy(busy)
   );

   // Clock
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int m_beat = 0;
   logic [ADDR_W-1:0] exp_q[$];
   logic [1:0]        owner_q[$];

   typedef struct {
      logic [3:0] req_valid;
      logic       addr_ready;
      logic [3:0] exp_grant;
      logic       exp_addr_valid;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [ADDR_W-1:0] addr_of(input int i);
      return bus.req_addr[i*ADDR_W +: ADDR_W];
   endfunction

   // Reset block: drives idle inputs and clears the bench model
   task automatic do_reset();
      rst = 1'b1;
      unit_en = 1'b1;
      mode = 1'b1;
      bus.req_addr_valid = '0;
      bus.ldq_addr_ready = 1'b0;
      bus.ldq_data_valid = 1'b0;
      bus.ldq_data = '0;
      bus.req_data_ready = '0;
      exp_q.delete();
      owner_q.delete();
      m_beat = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One address-channel cycle: drive, then check grant/valid and the address scoreboard
   task automatic addr_cycle(input logic [3:0] rv, input logic ar, input logic [3:0] eg, input logic ev);
      @(posedge clk);
      #1;
      bus.req_addr_valid = rv;
      bus.ldq_addr_ready = ar;
      @(negedge clk);
      chk("req_addr_ready", bus.req_addr_ready, eg);
      chk("ldq_addr_valid", bus.ldq_addr_valid, ev);
      if (ev && ar) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL addr_sb: got %0h expected none", bus.ldq_addr);
         end else begin
            chk("ldq_addr", bus.ldq_addr, exp_q.pop_front());
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (eg[i]) begin
            exp_q.push_back(addr_of(i));
            owner_q.push_back(2'(i));
         end
      end
   endtask

   // Stream n data beats; all requesters stall for stall_n cycles at model beat stall_at
   task automatic run_beats(input int n, input int stall_at, input int stall_n);
      int sent = 0;
      int stalled = 0;
      int guard = 0;
      logic [3:0] rdy;
      logic exp_ready;
      logic [3:0] exp_valid;
      while (sent < n) begin
         guard++;
         if (guard > n + 100) begin
            total++; bad++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", sent, n);
            break;
         end
         @(posedge clk);
         #1;
         bus.ldq_data_valid = 1'b1;
         for (int w = 0; w < DATA_W/32; w++) bus.ldq_data[w*32 +: 32] = $urandom();
         rdy = 4'b1111;
         if (m_beat == stall_at && stalled < stall_n) begin
            rdy = 4'b0000;
            stalled++;
         end
         bus.req_data_ready = rdy;
         @(negedge clk);
         exp_ready = (owner_q.size() != 0) && rdy[owner_q[0]];
         exp_valid = (owner_q.size() != 0) ? (4'b0001 << owner_q[0]) : 4'b0000;
         chk("ldq_data_ready", bus.ldq_data_ready, exp_ready);
         chk("req_data_valid", bus.req_data_valid, exp_valid);
         if (rdy == 4'b0000) chk("beat_ctr_hold", dut.beat_ctr, 5'(stall_at));
         if (exp_ready) begin
            chk_data("req_data", bus.req_data, bus.ldq_data);
            sent++;
            m_beat++;
            if (m_beat == BEATS) begin
               m_beat = 0;
               void'(owner_q.pop_front());
            end
         end
      end
      @(posedge clk);
      #1;
      bus.ldq_data_valid = 1'b0;
      bus.req_data_ready = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Four requesters always valid: grants 0,1,2,3,0,1,2,3 then credits saturate
      vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0};
      vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
      vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
      vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
      vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
      vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
      vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
      vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
      vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1};
      vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
      vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

      bus.req_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_ldq_addr_valid", bus.ldq_addr_valid, 1'b0);
      chk("rst_ldq_addr", bus.ldq_addr, 16'h0);
      chk("rst_req_addr_ready", bus.req_addr_ready, 4'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ldq_data_ready", bus.ldq_data_ready, 1'b0);

      for (int v = 0; v < 11; v++) begin
         addr_cycle(vecs[v].req_valid, vecs[v].addr_ready, vecs[v].exp_grant, vecs[v].exp_addr_valid);
      end
      chk("sat_credit0", dut.credit[0], 2'd2);
      chk("sat_credit3", dut.credit[3], 2'd2);
      chk("sat_busy", busy, 1'b1);

      // Return all eight bursts in grant order
      run_beats(8 * BEATS, -1, 0);
      @(negedge clk);
      chk("drain_busy", busy, 1'b0);
      for (int i = 0; i < NUM_REQ; i++) chk("drain_credit", dut.credit[i], 2'd0);

      // Single request from req 2, then an address stall with unit_en dropping
      do_reset();
      bus.req_addr[2*ADDR_W +: ADDR_W] = 16'h0042;
      addr_cycle(4'b0100, 1'b0, 4'b0100, 1'b0);
      addr_cycle(4'b0000, 1'b0, 4'b0000, 1'b1);
      chk("r2_ldq_addr", bus.ldq_addr, 16'h0042);
      chk("r2_credit2", dut.credit[2], 2'd1);
      for (int c = 0; c < 5; c++) begin
         unit_en = (c < 2);
         addr_cycle(4'b0001, 1'b0, 4'b0000, 1'b1);
         chk("stall_ldq_addr", bus.ldq_addr, 16'h0042);
      end
      unit_en = 1'b1;
      addr_cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
      addr_cycle(4'b0000, 1'b0, 4'b0000, 1'b0);
      chk("r2_busy_pending", busy, 1'b1);

      // Reset mid-operation drops the outstanding load
      do_reset();
      bus.ldq_data_valid = 1'b1;
      bus.req_data_ready = 4'b1111;
      @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_credit2", dut.credit[2], 2'd0);
      chk("empty_data_ready", bus.ldq_data_ready, 1'b0);
      chk("empty_data_valid", bus.req_data_valid, 4'b0);
      bus.ldq_data_valid = 1'b0;
      bus.req_data_ready = '0;

      // Grants to req 1 then req 3, 64 beats, requester stall at beat 10
      do_reset();
      bus.req_addr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      addr_cycle(4'b1010, 1'b1, 4'b0010, 1'b0);
      addr_cycle(4'b1010, 1'b1, 4'b1000, 1'b1);
      addr_cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
      addr_cycle(4'b0000, 1'b0, 4'b0000, 1'b0);
      run_beats(2 * BEATS, 10, 3);
      @(negedge clk);
      chk("b13_credit1", dut.credit[1], 2'd0);
      chk("b13_credit3", dut.credit[3], 2'd0);
      chk("b13_busy", busy, 1'b0);

      // Last beat of req 0 coincides with a new grant to req 0 at credit 1
      do_reset();
      bus.req_addr = {16'h0d00, 16'h0c00, 16'h0b00, 16'h0a00};
      addr_cycle(4'b0001, 1'b1, 4'b0001, 1'b0);
      addr_cycle(4'b0000, 1'b1, 4'b0000, 1'b1);
      run_beats(BEATS - 1, -1, 0);
      @(posedge clk);
      #1;
      bus.req_addr[0 +: ADDR_W] = 16'h0abc;
      bus.req_addr_valid = 4'b0001;
      bus.ldq_addr_ready = 1'b0;
      bus.ldq_data_valid = 1'b1;
      bus.req_data_ready = 4'b1111;
      @(negedge clk);
      chk("last_req_addr_ready", bus.req_addr_ready, 4'b0001);
      chk("last_ldq_data_ready", bus.ldq_data_ready, 1'b1);
      chk("last_req_data_valid", bus.req_data_valid, 4'b0001);
      @(posedge clk);
      #1;
      bus.req_addr_valid = '0;
      bus.ldq_data_valid = 1'b0;
      bus.req_data_ready = '0;
      @(negedge clk);
      chk("last_credit0", dut.credit[0], 2'd1);
      chk("last_ordq_used", dut.ordq_used, 5'd1);
      chk("last_ldq_addr_valid", bus.ldq_addr_valid, 1'b1);
      chk("last_ldq_addr", bus.ldq_addr, 16'h0abc);
      chk("last_busy", busy, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
